// File: rtl/dcache_miss_ctrl.sv
// dCache miss handler: stalls the CPU on a lookup miss, writes back a dirty
// victim, refills the line word by word from memory, then writes the tag.
module dcache_miss_ctrl #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_NUM     = 4,
  localparam int WAY_W       = $clog2(LINE_NUM),
  localparam int INDEX_WIDTH = 32 - TAG_WIDTH - OFFSET_WIDTH,
  localparam int WORD_W      = OFFSET_WIDTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [31:0]            cpu_addr,
  input  logic                   hit,
  input  logic [WAY_W-1:0]       victim_way,
  input  logic                   victim_dirty,
  input  logic [TAG_WIDTH-1:0]   victim_tag,
  output logic                   cpu_stall,
  output logic [1:0]             state,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  output logic [WAY_W-1:0]       line_way,
  output logic [INDEX_WIDTH-1:0] line_index,
  output logic [WORD_W-1:0]      line_word,
  output logic                   line_we,
  output logic                   tag_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 cur, nxt;
  logic [WORD_W-1:0]      cnt, cnt_n;
  logic [TAG_WIDTH-1:0]   miss_tag, miss_tag_n;
  logic [INDEX_WIDTH-1:0] miss_index, miss_index_n;
  logic [WAY_W-1:0]       way_q, way_n;
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_n;
  logic                   miss;

  // Byte offset within the line plays no part in a whole-line fill.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];

  assign miss = cpu_req && !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= IDLE;
      cnt        <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
      way_q      <= '0;
      vtag_q     <= '0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_n;
      miss_tag   <= miss_tag_n;
      miss_index <= miss_index_n;
      way_q      <= way_n;
      vtag_q     <= vtag_n;
    end
  end

  always_comb begin
    nxt          = cur;
    cnt_n        = cnt;
    miss_tag_n   = miss_tag;
    miss_index_n = miss_index;
    way_n        = way_q;
    vtag_n       = vtag_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    case (cur)
      IDLE: begin
        if (miss) begin
          miss_tag_n   = cpu_addr[31 -: TAG_WIDTH];
          miss_index_n = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          way_n        = victim_way;
          vtag_n       = victim_tag;
          cnt_n        = '0;
          nxt          = victim_dirty ? WB : REFILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {vtag_q, miss_index, cnt, 2'b00};
        if (mem_ack) begin
          cnt_n = cnt + WORD_W'(1);
          if (cnt == '1) nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_index, cnt, 2'b00};
        line_we  = mem_ack;
        if (mem_ack) begin
          cnt_n = cnt + WORD_W'(1);
          if (cnt == '1) nxt = DONE;
        end
      end
      DONE: begin
        tag_we = 1'b1;
        nxt    = IDLE;
      end
    endcase
  end

  // The only input-dependent stall term is masked so reset forces every output low.
  assign cpu_stall  = !reset && (((cur == IDLE) && miss) || (cur != IDLE));
  assign state      = cur;
  assign line_way   = way_q;
  assign line_index = miss_index;
  assign line_word  = cnt;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized self-checking bench for dcache_miss_ctrl against a transaction-level
// model: expected address list, ack schedule and stall length per miss.
module tb_dcache_miss_ctrl;

  localparam int WPL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        hit;
  logic [1:0]  victim_way;
  logic        victim_dirty;
  logic [19:0] victim_tag;
  logic        cpu_stall;
  logic [1:0]  state;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [1:0]  line_way;
  logic [6:0]  line_index;
  logic [2:0]  line_word;
  logic        line_we;
  logic        tag_we;

  int checks   = 0;
  int failures = 0;

  dcache_miss_ctrl #(.TAG_WIDTH(20), .OFFSET_WIDTH(5), .LINE_NUM(4)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit(hit),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .cpu_stall(cpu_stall), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .line_way(line_way),
    .line_index(line_index), .line_word(line_word), .line_we(line_we), .tag_we(tag_we)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: ack every cycle, 1: ack every 3rd cycle, 2: random acks.
  // Entered and left at posedge+1.
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                          input logic [19:0] vtag, input int mode, input bit drop);
    bit          ack_pat[600];
    logic [31:0] exp_addr[$];
    bit          exp_we[$];
    int          n, got, last_c, stall_n, tag_n, lwe_n, seq;
    logic [1:0]  last_st;
    logic        prev_pend, done;
    logic [31:0] prev_addr;

    n = dirty ? 2 * WPL : WPL;
    for (int c = 0; c < 600; c++) begin
      case (mode)
        0:       ack_pat[c] = 1'b1;
        1:       ack_pat[c] = (c % 3 == 2);
        default: ack_pat[c] = (c >= 400) || ($urandom_range(0, 2) == 0);
      endcase
    end
    // Cycle 0 is the IDLE cycle; the Nth ack after it ends the memory phase.
    got = 0; last_c = 0;
    for (int c = 1; c < 600 && got < n; c++)
      if (ack_pat[c]) begin got++; last_c = c; end
    if (dirty)
      for (int w = 0; w < WPL; w++) begin
        exp_addr.push_back({vtag, addr[11:5], 3'(w), 2'b00});
        exp_we.push_back(1'b1);
      end
    for (int w = 0; w < WPL; w++) begin
      exp_addr.push_back({addr[31:5], 3'(w), 2'b00});
      exp_we.push_back(1'b0);
    end

    cpu_req = 1'b1; hit = 1'b0; cpu_addr = addr;
    victim_way = way; victim_dirty = dirty; victim_tag = vtag;
    stall_n = 0; tag_n = 0; lwe_n = 0; seq = 0; last_st = 2'd0;
    prev_pend = 1'b0; prev_addr = '0; done = 1'b0;

    for (int c = 0; c < 600; c++) begin
      mem_ack = ack_pat[c];
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (state != last_st) begin seq = (seq << 2) | int'(state); last_st = state; end
      if (mem_req) begin
        if (exp_addr.size() == 0) check_eq("req_overrun", mem_req, 1'b0);
        else begin
          check_eq("mem_addr", mem_addr, exp_addr[0]);
          check_eq("mem_we", mem_we, exp_we[0]);
          if (mem_ack) begin void'(exp_addr.pop_front()); void'(exp_we.pop_front()); end
        end
        if (prev_pend) check_eq("addr_hold", mem_addr, prev_addr);
      end
      if (line_we) begin
        check_eq("line_way", line_way, way);
        check_eq("line_index", line_index, addr[11:5]);
        check_eq("line_word", line_word, lwe_n);
        lwe_n++;
      end
      if (tag_we) tag_n++;
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      done      = tag_we;
      @(posedge clk); #1;
      if (drop) begin
        cpu_req = 1'b0;
        victim_way = 2'($urandom); victim_dirty = 1'($urandom);
        victim_tag = 20'($urandom); cpu_addr = $urandom;
      end
      if (done) break;
    end
    hit = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;

    check_eq("stall_cycles", stall_n, last_c + 2);
    check_eq("words_left", exp_addr.size(), 0);
    check_eq("tag_we_count", tag_n, 1);
    check_eq("line_we_count", lwe_n, WPL);
    check_eq("state_seq", seq, dirty ? 32'h1B : 32'h0B);
    check_eq("back_idle", state, 2'd0);
  endtask

  task automatic hit_stream(input int cycles);
    cpu_req = 1'b1; hit = 1'b1; cpu_addr = $urandom;
    for (int c = 0; c < cycles; c++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      check_eq("hit_state", state, 2'd0);
      check_eq("hit_stall", cpu_stall, 1'b0);
      check_eq("hit_mem_req", mem_req, 1'b0);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; hit = 1'b0;
    victim_way = '0; victim_dirty = 1'b0; victim_tag = '0; mem_ack = 1'b0;
    #3;
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_stall", cpu_stall, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_line", {line_way, line_index, line_word, line_we, tag_we, mem_we}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    run_miss(32'h1234_5660, 2'd2, 1'b0, 20'h0, 0, 1'b0);
    run_miss(32'h1234_5660, 2'd1, 1'b1, 20'hABCDE, 0, 1'b0);
    run_miss(32'h8765_4320, 2'd3, 1'b1, 20'h13579, 1, 1'b0);
    hit_stream(20);

    // Abort a clean refill after three words.
    cpu_addr = 32'h0F0F_0F20; victim_way = 2'd1; victim_dirty = 1'b0; victim_tag = '0;
    hit = 1'b0; cpu_req = 1'b1; mem_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_rst_state", state, 2'd2);
    check_eq("pre_rst_word", line_word, 3'd3);
    #1 reset = 1'b1;
    #1;
    check_eq("abort_mem_req", mem_req, 1'b0);
    check_eq("abort_stall", cpu_stall, 1'b0);
    check_eq("abort_state", state, 2'd0);
    check_eq("abort_tag_we", tag_we, 1'b0);
    check_eq("abort_word", line_word, 3'd0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_miss(32'h0F0F_0F20, 2'd1, 1'b0, 20'h0, 0, 1'b0);

    run_miss(32'hCAFE_1AE0, 2'd0, 1'b1, 20'h55AA5, 0, 1'b1);

    for (int i = 0; i < 6; i++)
      run_miss($urandom, 2'($urandom), 1'($urandom), 20'($urandom), 2, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
